// File: rtl/wb_uart_slave_if.sv
// Wishbone request/response bundle between interconnect port S1 and the UART slave.
// Signal names are seen from the slave side: *_i flows toward the slave.
interface wb_uart_slave_if;
  logic [31:0] wb_dat_i;
  logic [8:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_uart_slave.sv
// Wishbone-mapped 8N1 UART with TX/RX FIFOs, programmable bit period and a level interrupt.
// Bus side effects happen on the edge that raises the registered acknowledge.
module wb_uart_slave #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DEFAULT = 16'd433
) (
  input  logic           clk_i,
  input  logic           rst_n,
  wb_uart_slave_if.slave wb,
  input  logic           uart_rx_i,
  output logic           uart_tx_o,
  output logic           irq_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [6:0] REG_TXDATA = 7'd0;
  localparam logic [6:0] REG_RXDATA = 7'd1;
  localparam logic [6:0] REG_STATUS = 7'd2;
  localparam logic [6:0] REG_BAUD   = 7'd3;
  localparam logic [6:0] REG_CTRL   = 7'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  typedef struct packed {
    logic [3:0] rx_count;
    logic [3:0] tx_count;
    logic       tx_ovf;
    logic       frame_err;
    logic       rx_ovf;
    logic       tx_busy;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;
  } status_t;

  // Bus and register state
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d, rdata;
  logic        acc, wr, rd;
  logic [6:0]  reg_sel;
  logic [15:0] baud_q, baud_d, baud_merged;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, ferr_q, ferr_d;
  logic        irq_q, irq_d;
  status_t     status;

  // FIFO state
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_wr_byte, tx_push, tx_pop, rx_push, rx_pop;

  // TX engine
  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_tmr_q, tx_tmr_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_busy;

  // RX engine
  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_tmr_q, rx_tmr_d, rx_half;
  logic [16:0] rx_span;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_stop_sample, rx_ferr_set, rx_ovf_set;

  logic unused_bits;
  assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_dat_i[31:16], wb.wb_sel_i[3:2]};

  assign acc     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr      = acc & wb.wb_we_i;
  assign rd      = acc & ~wb.wb_we_i;
  assign reg_sel = wb.wb_adr_i[8:2];

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_wr_byte = wr & (reg_sel == REG_TXDATA) & wb.wb_sel_i[0];
  assign tx_push    = tx_wr_byte & ~tx_full;
  assign rx_pop     = rd & (reg_sel == REG_RXDATA) & ~rx_empty;

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = irq_q;

  always_comb begin
    status           = '0;
    status.rx_count  = 4'(rx_cnt_q);
    status.tx_count  = 4'(tx_cnt_q);
    status.tx_ovf    = tx_ovf_q;
    status.frame_err = ferr_q;
    status.rx_ovf    = rx_ovf_q;
    status.tx_busy   = tx_busy;
    status.rx_empty  = rx_empty;
    status.rx_full   = rx_full;
    status.tx_empty  = tx_empty;
    status.tx_full   = tx_full;
  end

  always_comb begin
    baud_merged = baud_q;
    if (wb.wb_sel_i[0]) baud_merged[7:0]  = wb.wb_dat_i[7:0];
    if (wb.wb_sel_i[1]) baud_merged[15:8] = wb.wb_dat_i[15:8];
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_RXDATA: if (!rx_empty) rdata = {23'b0, 1'b1, rx_mem[rx_rp_q]};
      REG_STATUS: rdata = {16'b0, status};
      REG_BAUD:   rdata = {16'b0, baud_q};
      REG_CTRL:   rdata = {28'b0, ctrl_q};
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    ack_d    = acc;
    dat_d    = rd ? rdata : 32'b0;
    baud_d   = baud_q;
    ctrl_d   = ctrl_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    ferr_d   = ferr_q;
    if (wr && reg_sel == REG_STATUS && wb.wb_sel_i[0]) begin
      if (wb.wb_dat_i[5]) rx_ovf_d = 1'b0;
      if (wb.wb_dat_i[6]) ferr_d   = 1'b0;
      if (wb.wb_dat_i[7]) tx_ovf_d = 1'b0;
    end
    if (wr && reg_sel == REG_BAUD)
      baud_d = (baud_merged < 16'd3) ? 16'd3 : baud_merged;
    if (wr && reg_sel == REG_CTRL && wb.wb_sel_i[0])
      ctrl_d = wb.wb_dat_i[3:0];
    // A new event wins over a W1C arriving on the same edge.
    if (tx_wr_byte && tx_full) tx_ovf_d = 1'b1;
    if (rx_ovf_set)            rx_ovf_d = 1'b1;
    if (rx_ferr_set)           ferr_d   = 1'b1;
    irq_d = (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      baud_q   <= BAUD_DEFAULT;
      ctrl_q   <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      ferr_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      baud_q   <= baud_d;
      ctrl_q   <= ctrl_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      ferr_q   <= ferr_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + PW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + PW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + PW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + CW'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - CW'(1);
        default: tx_cnt_q <= tx_cnt_q;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + CW'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - CW'(1);
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  // NOTE: FIFO storage is left unreset; the counts guard every read, so stale entries are never observed.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp_q] <= wb.wb_dat_i[7:0];
    if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
  end

  // ---------------- TX engine ----------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= ST_IDLE;
      tx_tmr_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  // The bit timer reloads from BAUD at each boundary, so a BAUD write applies from the next bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    case (tx_state_q)
      ST_IDLE: if (tx_pop) begin
        tx_state_d = ST_START;
        tx_tmr_d   = baud_q;
        tx_sh_d    = tx_mem[tx_rp_q];
      end
      ST_START: if (tx_tmr_q == '0) begin
        tx_state_d = ST_DATA;
        tx_tmr_d   = baud_q;
        tx_bit_d   = '0;
      end else tx_tmr_d = tx_tmr_q - 16'd1;
      ST_DATA: if (tx_tmr_q == '0) begin
        tx_tmr_d = baud_q;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
        else                  tx_bit_d   = tx_bit_q + 3'd1;
      end else tx_tmr_d = tx_tmr_q - 16'd1;
      ST_STOP: if (tx_tmr_q == '0) tx_state_d = ST_IDLE;
               else                tx_tmr_d   = tx_tmr_q - 16'd1;
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    uart_tx_o = 1'b1;
    tx_pop    = 1'b0;
    tx_busy   = (tx_state_q != ST_IDLE);
    case (tx_state_q)
      ST_IDLE:  tx_pop    = ctrl_q[0] & ~tx_empty;
      ST_START: uart_tx_o = 1'b0;
      ST_DATA:  uart_tx_o = tx_sh_q[0];
      default:  uart_tx_o = 1'b1;
    endcase
  end

  // ---------------- RX engine ----------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_tmr_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // Start bit is rechecked (BAUD+1)/2 cycles after the falling edge, i.e. mid-bit.
  assign rx_span = {1'b0, baud_q} + 17'd1;
  assign rx_half = rx_span[16:1] - 16'd1;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    case (rx_state_q)
      ST_IDLE: if (ctrl_q[1] && rx_prev_q && !rx_s2_q) begin
        rx_state_d = ST_START;
        rx_tmr_d   = rx_half;
      end
      ST_START: if (rx_tmr_q == '0) begin
        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        rx_tmr_d   = baud_q;
        rx_bit_d   = '0;
      end else rx_tmr_d = rx_tmr_q - 16'd1;
      ST_DATA: if (rx_tmr_q == '0) begin
        rx_tmr_d = baud_q;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end else rx_tmr_d = rx_tmr_q - 16'd1;
      ST_STOP: if (rx_tmr_q == '0) rx_state_d = ST_IDLE;
               else                rx_tmr_d   = rx_tmr_q - 16'd1;
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_stop_sample = (rx_state_q == ST_STOP) && (rx_tmr_q == '0);
    rx_ferr_set    = rx_stop_sample & ~rx_s2_q;
    rx_ovf_set     = rx_stop_sample & rx_s2_q & rx_full;
    rx_push        = rx_stop_sample & rx_s2_q & ~rx_full;
  end

endmodule

// File: tb/tb_wb_uart_slave.sv
// Directed bench for wb_uart_slave: register vector table plus hand-written
// sequences for serial timing, FIFO limits, sticky flags, interrupt and reset.
module tb_wb_uart_slave;
  localparam logic [8:0] A_TX   = 9'h000;
  localparam logic [8:0] A_RX   = 9'h004;
  localparam logic [8:0] A_STAT = 9'h008;
  localparam logic [8:0] A_BAUD = 9'h00C;
  localparam logic [8:0] A_CTRL = 9'h010;
  localparam int BP_RX = 8;

  typedef struct {
    logic [8:0]  adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic uart_rx;
  logic uart_tx;
  logic irq;

  int n_checks = 0;
  int n_errors = 0;
  int n_access = 0;
  int ack_seen = 0;
  int ack_b2b  = 0;
  logic ack_prev = 1'b0;

  wb_uart_slave_if wb_if ();

  wb_uart_slave #(.FIFO_DEPTH(8), .BAUD_DEFAULT(16'd433)) dut (
    .clk_i    (clk),
    .rst_n    (rst_n),
    .wb       (wb_if),
    .uart_rx_i(uart_rx),
    .uart_tx_o(uart_tx),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_if.wb_ack_o) ack_seen <= ack_seen + 1;
    if (wb_if.wb_ack_o && ack_prev) ack_b2b <= ack_b2b + 1;
    ack_prev <= wb_if.wb_ack_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_access(input logic [8:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat, output logic [31:0] rdat);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    wb_if.wb_adr_i = adr;
    wb_if.wb_we_i  = we;
    wb_if.wb_sel_i = sel;
    wb_if.wb_dat_i = wdat;
    wb_if.wb_cyc_i = 1'b1;
    wb_if.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    while (!wb_if.wb_ack_o && waited < 16) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!wb_if.wb_ack_o) check("ack_timeout", 32'(wb_if.wb_ack_o), 32'd1);
    rdat = wb_if.wb_dat_o;
    n_access++;
    @(posedge clk); #1;
    wb_if.wb_cyc_i = 1'b0;
    wb_if.wb_stb_i = 1'b0;
    wb_if.wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [8:0] adr, input logic [31:0] wdat, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_access(adr, 1'b1, sel, wdat, dummy);
  endtask

  task automatic wb_read(input logic [8:0] adr, output logic [31:0] rdat);
    wb_access(adr, 1'b0, 4'hF, 32'h0, rdat);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (BP_RX) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  task automatic run_t1();
    logic [9:0]  frame;
    logic [31:0] d;
    frame = {1'b1, 8'hA5, 1'b0};
    wb_write(A_BAUD, 32'd3, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'h1);
    wb_write(A_TX, 32'hA5, 4'h1);
    fork
      begin
        int w;
        w = 0;
        while (uart_tx && w < 20) begin
          @(posedge clk); #1;
          w++;
        end
        check("t1_start_seen", 32'(uart_tx), 32'd0);
        for (int k = 0; k < 40; k++) begin
          check($sformatf("t1_line_bit%0d_cyc%0d", k / 4, k % 4), 32'(uart_tx), 32'(frame[k / 4]));
          @(posedge clk); #1;
        end
      end
      begin
        repeat (8) @(posedge clk);
        wb_read(A_STAT, d);
        check("t1_status_busy", d, 32'h0000_001A);
      end
    join
    check("t1_line_idle", 32'(uart_tx), 32'd1);
    wb_read(A_STAT, d);
    check("t1_status_done", d, 32'h0000_000A);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [19];
    logic [31:0] d;

    rst_n          = 1'b0;
    uart_rx        = 1'b1;
    wb_if.wb_adr_i = '0;
    wb_if.wb_dat_i = '0;
    wb_if.wb_sel_i = '0;
    wb_if.wb_we_i  = 1'b0;
    wb_if.wb_cyc_i = 1'b0;
    wb_if.wb_stb_i = 1'b0;

    vecs[0]  = '{A_STAT, 1'b0, 4'hF, 32'h0,         32'h0000_000A};
    vecs[1]  = '{A_BAUD, 1'b0, 4'hF, 32'h0,         32'h0000_01B1};
    vecs[2]  = '{A_CTRL, 1'b0, 4'hF, 32'h0,         32'h0};
    vecs[3]  = '{A_RX,   1'b0, 4'hF, 32'h0,         32'h0};
    vecs[4]  = '{A_TX,   1'b0, 4'hF, 32'h0,         32'h0};
    vecs[5]  = '{A_BAUD, 1'b1, 4'hF, 32'h0000_0002, 32'h0};
    vecs[6]  = '{A_BAUD, 1'b0, 4'hF, 32'h0,         32'h0000_0003};
    vecs[7]  = '{A_BAUD, 1'b1, 4'h1, 32'hFFFF_FF07, 32'h0};
    vecs[8]  = '{A_BAUD, 1'b0, 4'hF, 32'h0,         32'h0000_0007};
    vecs[9]  = '{A_BAUD, 1'b1, 4'h2, 32'h0000_1200, 32'h0};
    vecs[10] = '{A_BAUD, 1'b0, 4'hF, 32'h0,         32'h0000_1207};
    vecs[11] = '{A_BAUD, 1'b1, 4'h3, 32'h0000_0000, 32'h0};
    vecs[12] = '{A_BAUD, 1'b0, 4'hF, 32'h0,         32'h0000_0003};
    vecs[13] = '{A_CTRL, 1'b1, 4'h1, 32'hFFFF_FFFA, 32'h0};
    vecs[14] = '{A_CTRL, 1'b0, 4'hF, 32'h0,         32'h0000_000A};
    vecs[15] = '{A_CTRL, 1'b1, 4'h2, 32'h0000_0005, 32'h0};
    vecs[16] = '{A_CTRL, 1'b0, 4'hF, 32'h0,         32'h0000_000A};
    vecs[17] = '{9'h040, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[18] = '{9'h1FC, 1'b0, 4'hF, 32'h0,         32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(wb_if.wb_ack_o), 32'd0);
    check("rst_dat", wb_if.wb_dat_o, 32'd0);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;

    // Register vectors
    for (int i = 0; i < 19; i++) begin
      wb_access(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].wdat, d);
      if (!vecs[i].we) check($sformatf("vec%0d_read", i), d, vecs[i].exp);
    end
    wb_read(9'h040, d);
    check("unmapped_read", d, 32'h0);
    check("irq_tx_empty", 32'(irq), 32'd1);
    wb_write(A_CTRL, 32'h0, 4'h1);
    check("irq_off", 32'(irq), 32'd0);

    // T1: TX frame timing
    run_t1();

    // T2/T3: pushes with tx disabled, overflow, W1C
    wb_write(A_CTRL, 32'h0, 4'h1);
    for (int i = 0; i < 3; i++) wb_write(A_TX, 32'(i), 4'h1);
    wb_read(A_STAT, d);
    check("t2_three_pushes", d, 32'h0000_0308);
    for (int i = 3; i < 9; i++) wb_write(A_TX, 32'(i), 4'h1);
    wb_read(A_STAT, d);
    check("t3_full_ovf", d, 32'h0000_0889);
    wb_write(A_STAT, 32'hFF, 4'h2);
    wb_read(A_STAT, d);
    check("t3_w1c_no_sel0", d, 32'h0000_0889);
    wb_write(A_STAT, 32'h80, 4'h1);
    wb_read(A_STAT, d);
    check("t3_w1c_txovf", d, 32'h0000_0809);
    check("t2_ack_count", 32'(ack_seen), 32'(n_access));
    check("t2_ack_b2b", 32'(ack_b2b), 32'd0);

    // T4: single RX frame
    do_reset();
    wb_write(A_BAUD, 32'd7, 4'hF);
    wb_write(A_CTRL, 32'h2, 4'h1);
    send_rx(8'h3C, 1'b1);
    repeat (4) @(posedge clk);
    wb_read(A_RX, d);
    check("t4_rxdata", d, 32'h0000_013C);
    wb_read(A_RX, d);
    check("t4_rxdata_empty", d, 32'h0);
    wb_read(A_STAT, d);
    check("t4_status", d, 32'h0000_000A);

    // T5: framing error then RX overflow
    send_rx(8'h55, 1'b0);
    repeat (4) @(posedge clk);
    wb_read(A_STAT, d);
    check("t5_frame_err", d, 32'h0000_004A);
    for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i), 1'b1);
    repeat (4) @(posedge clk);
    wb_read(A_STAT, d);
    check("t5_rx_ovf", d, 32'h0000_8066);
    wb_write(A_STAT, 32'h20, 4'h1);
    wb_read(A_STAT, d);
    check("t5_w1c_rxovf", d, 32'h0000_8046);
    wb_write(A_STAT, 32'h40, 4'h1);
    wb_read(A_STAT, d);
    check("t5_w1c_ferr", d, 32'h0000_8006);
    wb_read(A_RX, d);
    check("t5_first_byte", d, 32'h0000_0110);
    wb_read(A_STAT, d);
    check("t5_after_pop", d, 32'h0000_7002);

    // T6: RX interrupt and its release timing
    do_reset();
    wb_write(A_BAUD, 32'd7, 4'hF);
    wb_write(A_CTRL, 32'h6, 4'h1);
    check("t6_irq_idle", 32'(irq), 32'd0);
    send_rx(8'h81, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t6_irq_set", 32'(irq), 32'd1);
    @(posedge clk); #1;
    wb_if.wb_adr_i = A_RX;
    wb_if.wb_we_i  = 1'b0;
    wb_if.wb_sel_i = 4'hF;
    wb_if.wb_cyc_i = 1'b1;
    wb_if.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("t6_ack", 32'(wb_if.wb_ack_o), 32'd1);
    check("t6_rxdata", wb_if.wb_dat_o, 32'h0000_0181);
    check("t6_irq_in_ack", 32'(irq), 32'd1);
    @(posedge clk); #1;
    check("t6_irq_after_ack", 32'(irq), 32'd0);
    wb_if.wb_cyc_i = 1'b0;
    wb_if.wb_stb_i = 1'b0;

    // T6: asynchronous reset in the middle of a TX frame
    wb_write(A_BAUD, 32'd3, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'h1);
    wb_write(A_TX, 32'h00, 4'h1);
    repeat (10) @(posedge clk);
    #1;
    check("t6_tx_low_mid_frame", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_tx_high_in_reset", 32'(uart_tx), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("t6_tx_idle_after_reset", 32'(uart_tx), 32'd1);
    wb_read(A_STAT, d);
    check("t6_status_after_reset", d, 32'h0000_000A);
    wb_read(A_BAUD, d);
    check("t6_baud_after_reset", d, 32'h0000_01B1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
